// File: rtl/registerfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with busy scoreboard.
package registerfile_scoreboard_pkg;

    localparam int DEFAULT_WIDTH     = 64;
    localparam int DEFAULT_ADDR_BITS = 5;

    // Index of the highest register, which doubles as the hardwired-zero entry.
    function automatic int zero_reg_index(input int addr_bits);
        return (1 << addr_bits) - 1;
    endfunction

endpackage

// File: rtl/register.sv
// Plain n-bit storage register with load enable and synchronous clear.
module register #(
    parameter int n = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_enable,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    logic [n-1:0] value_q;
    logic [n-1:0] value_d;

    // Next value: load new data when enabled, otherwise hold.
    always_comb begin
        value_d = value_q;
        if (load_enable) begin
            value_d = d;
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/registerfile_scoreboard_scoreboard.sv
// Per-register busy bits plus a registered population count.
// A reservation beats a same-cycle writeback so the newest producer stays tracked.
module scoreboard
    import registerfile_scoreboard_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int ZERO_REG  = 1,
    parameter int DEPTH     = 2 ** ADDR_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reserve,
    input  logic [ADDR_BITS-1:0] reserve_address,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] address,
    output logic [DEPTH-1:0]     busy,
    output logic [ADDR_BITS:0]   busy_count
);

    localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(zero_reg_index(ADDR_BITS));

    logic [DEPTH-1:0]   busy_q;
    logic [DEPTH-1:0]   busy_d;
    logic [ADDR_BITS:0] busy_count_q;
    logic [ADDR_BITS:0] busy_count_d;

    // Next busy vector (reserve sets, write clears, reserve wins) and its popcount.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (reserve && reserve_address == ADDR_BITS'(i)) begin
                busy_d[i] = 1'b1;
            end else if (write && address == ADDR_BITS'(i)) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_IDX] = 1'b0;
        end
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (ADDR_BITS + 1)'(busy_d[i]);
        end
    end

    // Busy vector and count update together on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = busy_count_q;

endmodule

// File: rtl/registerfile_scoreboard.sv
// Two-read/one-write register file with write bypass, optional hardwired-zero
// top register and a busy scoreboard for pending writebacks.
module registerfile_scoreboard
    import registerfile_scoreboard_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] select_a,
    input  logic [ADDR_BITS-1:0] select_b,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic                 busy_a,
    output logic                 busy_b,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 write,
    input  logic                 reserve,
    input  logic [ADDR_BITS-1:0] reserve_address,
    output logic [ADDR_BITS:0]   busy_count
);

    localparam int                   DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(zero_reg_index(ADDR_BITS));

    logic [WIDTH-1:0] reg_value [DEPTH];
    logic [DEPTH-1:0] busy;

    // One storage register per entry; the zero register never loads.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic load_enable;
        assign load_enable = write && (address == ADDR_BITS'(i))
                             && !((ZERO_REG != 0) && (i == DEPTH - 1));
        register #(.n(WIDTH)) u_reg (
            .clock      (clock),
            .reset      (reset),
            .load_enable(load_enable),
            .d          (data_in),
            .q          (reg_value[i])
        );
    end

    scoreboard #(
        .ADDR_BITS(ADDR_BITS),
        .ZERO_REG (ZERO_REG),
        .DEPTH    (DEPTH)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .reserve        (reserve),
        .reserve_address(reserve_address),
        .write          (write),
        .address        (address),
        .busy           (busy),
        .busy_count     (busy_count)
    );

    logic is_zero_a;
    logic is_zero_b;
    logic fwd_a;
    logic fwd_b;

    // Read muxes with forwarding; a forwarded value clears busy unless re-reserved.
    always_comb begin
        is_zero_a = (ZERO_REG != 0) && (select_a == ZERO_IDX);
        is_zero_b = (ZERO_REG != 0) && (select_b == ZERO_IDX);
        fwd_a     = (BYPASS != 0) && write && (address == select_a) && !is_zero_a;
        fwd_b     = (BYPASS != 0) && write && (address == select_b) && !is_zero_b;

        out_a = reg_value[select_a];
        if (is_zero_a) begin
            out_a = '0;
        end else if (fwd_a) begin
            out_a = data_in;
        end

        out_b = reg_value[select_b];
        if (is_zero_b) begin
            out_b = '0;
        end else if (fwd_b) begin
            out_b = data_in;
        end

        busy_a = busy[select_a] && !is_zero_a
                 && !(fwd_a && !(reserve && reserve_address == select_a));
        busy_b = busy[select_b] && !is_zero_b
                 && !(fwd_b && !(reserve && reserve_address == select_b));
    end

endmodule

// File: tb/tb_registerfile_scoreboard.sv
// Directed bench: expectations are queued when stimulus is driven and
// compared against the DUT outputs when they are sampled.
module tb_registerfile_scoreboard;

    localparam int WIDTH     = 64;
    localparam int ADDR_BITS = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [ADDR_BITS-1:0] select_a, select_b;
    logic [WIDTH-1:0]     out_a, out_b;
    logic                 busy_a, busy_b;
    logic [WIDTH-1:0]     data_in;
    logic [ADDR_BITS-1:0] address;
    logic                 write;
    logic                 reserve;
    logic [ADDR_BITS-1:0] reserve_address;
    logic [ADDR_BITS:0]   busy_count;

    registerfile_scoreboard #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(ADDR_BITS),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .select_a       (select_a),
        .select_b       (select_b),
        .out_a          (out_a),
        .out_b          (out_b),
        .busy_a         (busy_a),
        .busy_b         (busy_b),
        .data_in        (data_in),
        .address        (address),
        .write          (write),
        .reserve        (reserve),
        .reserve_address(reserve_address),
        .busy_count     (busy_count)
    );

    always #5 clock = ~clock;

    typedef enum int {K_OUT_A, K_OUT_B, K_BUSY_A, K_BUSY_B, K_COUNT} kind_t;
    typedef struct {
        kind_t       k;
        logic [63:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input kind_t k, input logic [63:0] v, input string tag);
        exp_t e;
        e.k   = k;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [63:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.k)
                K_OUT_A:  obs = out_a;
                K_OUT_B:  obs = out_b;
                K_BUSY_A: obs = 64'(busy_a);
                K_BUSY_B: obs = 64'(busy_b);
                default:  obs = 64'(busy_count);
            endcase
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write   = 1'b0;
        reserve = 1'b0;
    endtask

    initial begin
        reset = 1'b1; select_a = '0; select_b = '0; data_in = '0;
        address = '0; write = 1'b0; reserve = 1'b0; reserve_address = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: everything reads back zero and idle after reset
        for (int i = 0; i < 32; i++) begin
            select_a = ADDR_BITS'(i);
            select_b = ADDR_BITS'(31 - i);
            #1;
            expect_val(K_OUT_A, 64'h0, "rst_out_a");
            expect_val(K_OUT_B, 64'h0, "rst_out_b");
            expect_val(K_BUSY_A, 64'h0, "rst_busy_a");
            expect_val(K_BUSY_B, 64'h0, "rst_busy_b");
            expect_val(K_COUNT, 64'h0, "rst_count");
            check_pending();
        end
        tick();

        // 2: write reg 3 with same-cycle bypass on port B
        write = 1'b1; address = 5'd3; data_in = 64'hDEADBEEF_00000001;
        select_a = 5'd0; select_b = 5'd3;
        #1;
        expect_val(K_OUT_B, 64'hDEADBEEF_00000001, "bypass_b");
        expect_val(K_OUT_A, 64'h0, "unrelated_a");
        check_pending();
        tick();
        idle(); select_a = 5'd3; select_b = 5'd0;
        #1;
        expect_val(K_OUT_A, 64'hDEADBEEF_00000001, "stored_a");
        expect_val(K_OUT_B, 64'h0, "reg0_b");
        check_pending();

        // 3: zero register ignores writes, bypass and reservations
        write = 1'b1; address = 5'd31; data_in = 64'hFFFF;
        reserve = 1'b1; reserve_address = 5'd31;
        select_a = 5'd31; select_b = 5'd31;
        #1;
        expect_val(K_OUT_A, 64'h0, "zero_nobypass_a");
        expect_val(K_BUSY_A, 64'h0, "zero_busy_now");
        check_pending();
        tick();
        idle();
        #1;
        expect_val(K_OUT_A, 64'h0, "zero_out_a");
        expect_val(K_OUT_B, 64'h0, "zero_out_b");
        expect_val(K_BUSY_A, 64'h0, "zero_busy_a");
        expect_val(K_COUNT, 64'h0, "zero_count");
        check_pending();

        // 4: reserve 5, later write it back with bypass
        reserve = 1'b1; reserve_address = 5'd5; select_a = 5'd5;
        #1;
        expect_val(K_BUSY_A, 64'h0, "res5_before_edge");
        check_pending();
        tick();
        idle();
        #1;
        expect_val(K_BUSY_A, 64'h1, "res5_busy");
        expect_val(K_COUNT, 64'h1, "res5_count");
        check_pending();
        tick();
        write = 1'b1; address = 5'd5; data_in = 64'h55;
        #1;
        expect_val(K_BUSY_A, 64'h0, "wb5_busy_fwd");
        expect_val(K_OUT_A, 64'h55, "wb5_out_fwd");
        expect_val(K_COUNT, 64'h1, "wb5_count_before");
        check_pending();
        tick();
        idle();
        #1;
        expect_val(K_COUNT, 64'h0, "wb5_count_after");
        expect_val(K_BUSY_A, 64'h0, "wb5_busy_after");
        expect_val(K_OUT_A, 64'h55, "wb5_stored");
        check_pending();

        // 5: reserve and write reg 7 together; reservation wins
        reserve = 1'b1; reserve_address = 5'd7;
        write = 1'b1; address = 5'd7; data_in = 64'h77; select_a = 5'd7;
        #1;
        expect_val(K_OUT_A, 64'h77, "rw7_fwd");
        check_pending();
        tick();
        idle();
        #1;
        expect_val(K_OUT_A, 64'h77, "rw7_stored");
        expect_val(K_BUSY_A, 64'h1, "rw7_busy");
        expect_val(K_COUNT, 64'h1, "rw7_count");
        check_pending();
        reserve = 1'b1; reserve_address = 5'd7;
        write = 1'b1; address = 5'd7; data_in = 64'h78;
        #1;
        expect_val(K_OUT_A, 64'h78, "rerw7_fwd");
        expect_val(K_BUSY_A, 64'h1, "rerw7_busy_kept");
        check_pending();
        tick();
        idle();
        #1;
        expect_val(K_COUNT, 64'h1, "rerw7_count");
        check_pending();
        reset = 1'b1; write = 1'b1; address = 5'd9; data_in = 64'h99;
        tick();
        reset = 1'b0; idle(); select_a = 5'd9; select_b = 5'd7;
        #1;
        expect_val(K_OUT_A, 64'h0, "midrst_reg9");
        expect_val(K_OUT_B, 64'h0, "midrst_reg7");
        expect_val(K_BUSY_B, 64'h0, "midrst_busy7");
        expect_val(K_COUNT, 64'h0, "midrst_count");
        check_pending();

        // 6: several reservations, repeated reserve, and a write to an idle register
        reserve = 1'b1;
        reserve_address = 5'd1; tick();
        reserve_address = 5'd2; tick();
        reserve_address = 5'd3; tick();
        reserve_address = 5'd2; tick();
        idle(); select_a = 5'd2; select_b = 5'd1;
        #1;
        expect_val(K_COUNT, 64'h3, "multi_count3");
        expect_val(K_BUSY_A, 64'h1, "multi_busy2");
        expect_val(K_BUSY_B, 64'h1, "multi_busy1");
        check_pending();
        write = 1'b1; address = 5'd2; data_in = 64'h22;
        tick();
        idle();
        #1;
        expect_val(K_COUNT, 64'h2, "wb2_count");
        expect_val(K_BUSY_A, 64'h0, "wb2_busy");
        expect_val(K_OUT_A, 64'h22, "wb2_out");
        check_pending();
        write = 1'b1; address = 5'd4; data_in = 64'h44;
        tick();
        idle(); select_a = 5'd4;
        #1;
        expect_val(K_COUNT, 64'h2, "idlewr_count");
        expect_val(K_BUSY_A, 64'h0, "idlewr_busy");
        expect_val(K_OUT_A, 64'h44, "idlewr_out");
        expect_val(K_BUSY_B, 64'h1, "still_busy1");
        check_pending();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the directed sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, required completion within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/registerfile_scoreboard.md
Name: registerfile_scoreboard

Overview:
Parametrised multi-bit register file with two combinational read ports, one write port, write-to-read bypass, optional hardwired-zero top register, and a per-register busy scoreboard. The decode stage reserves destinations with `reserve`; writeback clears them with `write`. Dependent reads can stall on `busy_a`/`busy_b`. Drop-in successor for the fixed 64x32 file in the datapath.

Parameters:
WIDTH, 64, data bits per register
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS registers
ZERO_REG, 1, 1: register DEPTH-1 reads 0, ignores writes, never busy; 0: ordinary register
BYPASS, 1, 1: a same-cycle write is forwarded to the read outputs; 0: reads show stored value only

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all registers and busy bits
select_a  input  ADDR_BITS  read port A address
select_b  input  ADDR_BITS  read port B address
out_a  output  WIDTH  read data A
out_b  output  WIDTH  read data B
busy_a  output  1  register at select_a has a pending write
busy_b  output  1  register at select_b has a pending write
data_in  input  WIDTH  write data
address  input  ADDR_BITS  write address
write  input  1  write enable; also clears busy[address]
reserve  input  1  mark reserve_address pending
reserve_address  input  ADDR_BITS  register to reserve
busy_count  output  ADDR_BITS+1  number of busy registers

Behaviour:
- Reset: when reset=1 at a clock edge, all registers=0, all busy=0, busy_count=0. Reset overrides write and reserve in the same cycle. Read outputs are combinational, so they show 0 in the cycle after reset.
- Write:
  - write=1 at an edge loads data_in into register[address]; 1-cycle latency to the stored value.
  - With ZERO_REG=1, address=DEPTH-1 is a no-op.
- Read:
  - out_x = register[select_x], combinational.
  - With ZERO_REG=1 and select_x=DEPTH-1, out_x = 0 regardless of bypass.
  - Bypass (BYPASS=1): if write=1 and address==select_x (and not the zero register), out_x=data_in in the same cycle.
- Scoreboard, next-state per register i:
  - reserve && reserve_address==i → busy[i]=1.
  - else write && address==i → busy[i]=0.
  - else hold.
  - Reserve and write to the same address in one cycle: busy stays/becomes 1 (new producer wins); data is still written.
  - Reserving an already-busy register: stays 1, no count change.
  - Writing a non-busy register: legal, busy stays 0.
  - ZERO_REG=1: busy[DEPTH-1] is permanently 0 and reserve to it is ignored.
- busy_x:
  - busy[select_x], except forced to 0 when BYPASS=1, write=1, address==select_x and not (reserve && reserve_address==select_x). The forwarded value is valid that cycle.
  - Always 0 for the zero register.
- busy_count: registered population count of busy[]. Updates in the same edge as busy[]. Range 0..DEPTH (DEPTH-1 when ZERO_REG=1); cannot overflow.
- No internal FSM beyond the busy vector; no backpressure. Reserving a busy register is the issuer's responsibility (WAW is permitted and tracked as a single bit).

Decomposition:
- Shared package: ADDR_BITS/WIDTH defaults, and a ZERO_REG_INDEX function returning DEPTH-1.
- Storage reuses the existing `register` module (parameter n=WIDTH), one instance per entry, generated with load_enable = decoded address & write & not-zero-index.
- Read selection via a generate-built mux.
- One natural sub-module: `scoreboard` (busy vector, busy_count, reserve/write priority), so it is separately testable.

Test Plan:
1. Reset, then read all addresses → out_a=out_b=0, busy_a=busy_b=0, busy_count=0.
2. Write 0xDEADBEEF_00000001 to reg 3; next cycle select_a=3 → out_a=0xDEADBEEF_00000001. In the write cycle with BYPASS=1 and select_b=3, out_b already equals data_in.
3. ZERO_REG=1: write 0xFFFF to reg 31, reserve 31 → out_a(select 31)=0, busy_a=0, busy_count=0.
4. Reserve 5 at cycle t → busy_a(select 5)=1, busy_count=1. Write 0x55 to reg 5 at t+2 → busy_a=0 and out_a=0x55 in that cycle via bypass; busy_count=0 at t+3.
5. Same cycle: reserve 7 and write 0x77 to 7 → reg7=0x77, busy[7]=1, busy_count=1. Mid-test reset with write=1 to reg 9 → reg9=0, busy_count=0.
6. Reserve 1, 2, 3 on consecutive cycles, re-reserve 2 → busy_count=3. Write 2 → count 2. Write 4 (not busy) → count stays 2.
